// File: rtl/instr_transmitter.sv
// Instruction-image writer: splits 32-bit words into MSB-first bytes written to consecutive
// addresses, with an optional end-of-program terminator. Define INSTR_VERIFY_EN for readback verify.
module instr_transmitter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  output logic        word_ready,
  input  logic        seal,
  output logic [31:0] mem_waddr,
  output logic [7:0]  mem_wdata,
  output logic        mem_wren,
  output logic [31:0] mem_raddr,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] word_count,
  output logic        verify_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_ACCEPT, S_WR3, S_WR2, S_WR1, S_WR0,
    S_RD3, S_RD2, S_RD1, S_RD0, S_CMP, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ptr_q, ptr_d;
  logic [31:0] word_q, word_d;
  logic [31:0] count_q, count_d;
  logic        term_q, term_d;
  logic        err_q, err_d;

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      word_q  <= '0;
      count_q <= '0;
      term_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      word_q  <= word_d;
      count_q <= count_d;
      term_q  <= term_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every next-state variable is defaulted first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    word_d  = word_q;
    count_d = count_q;
    term_d  = term_q;
    err_d   = err_q;
    case (state_q)
      S_ACCEPT: begin
        if (seal) begin
          word_d  = 32'h0000_0000;
          term_d  = 1'b1;
          state_d = S_WR3;
        end else if (word_valid) begin
          word_d  = word_data;
          count_d = count_q + 32'd1;
          state_d = S_WR3;
        end
      end
      S_WR3: begin ptr_d = ptr_q + 32'd1; state_d = S_WR2; end
      S_WR2: begin ptr_d = ptr_q + 32'd1; state_d = S_WR1; end
      S_WR1: begin ptr_d = ptr_q + 32'd1; state_d = S_WR0; end
      S_WR0: begin
        ptr_d = ptr_q + 32'd1;
`ifdef INSTR_VERIFY_EN
        state_d = S_RD3;
`else
        state_d = term_q ? S_DONE : S_ACCEPT;
`endif
      end
`ifdef INSTR_VERIFY_EN
      // Read data lags the address by one cycle, so each state checks the previous byte.
      S_RD3: state_d = S_RD2;
      S_RD2: begin
        if (mem_rdata != word_q[31:24]) err_d = 1'b1;
        state_d = S_RD1;
      end
      S_RD1: begin
        if (mem_rdata != word_q[23:16]) err_d = 1'b1;
        state_d = S_RD0;
      end
      S_RD0: begin
        if (mem_rdata != word_q[15:8]) err_d = 1'b1;
        state_d = S_CMP;
      end
      S_CMP: begin
        if (mem_rdata != word_q[7:0]) err_d = 1'b1;
        state_d = term_q ? S_DONE : S_ACCEPT;
      end
`endif
      default: ;
    endcase
    // start overrides everything, abandoning any word still being written.
    if (start) begin
      ptr_d   = base_addr;
      count_d = '0;
      term_d  = 1'b0;
      err_d   = 1'b0;
      state_d = S_ACCEPT;
    end
  end

  always_comb begin
    mem_wren  = 1'b0;
    mem_wdata = 8'h00;
    mem_raddr = '0;
    case (state_q)
      S_WR3: begin mem_wren = 1'b1; mem_wdata = word_q[31:24]; end
      S_WR2: begin mem_wren = 1'b1; mem_wdata = word_q[23:16]; end
      S_WR1: begin mem_wren = 1'b1; mem_wdata = word_q[15:8];  end
      S_WR0: begin mem_wren = 1'b1; mem_wdata = word_q[7:0];   end
`ifdef INSTR_VERIFY_EN
      S_RD3: mem_raddr = ptr_q - 32'd4;
      S_RD2: mem_raddr = ptr_q - 32'd3;
      S_RD1: mem_raddr = ptr_q - 32'd2;
      S_RD0: mem_raddr = ptr_q - 32'd1;
`endif
      default: ;
    endcase
  end

`ifndef INSTR_VERIFY_EN
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
`endif

  assign mem_waddr  = ptr_q;
  assign word_ready = (state_q == S_ACCEPT) && !seal;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign word_count = count_q;
  assign verify_err = err_q;

endmodule
